// File: rtl/lif_membrane_integrator.sv
// Leaky integrate-and-fire membrane: accumulates MAC contributions, leaks and fires on each step.
// Optional LIF_SPIKE_CNT_EN adds a wrapping 16-bit spike_cnt output.
module lif_membrane_integrator #(
  parameter int unsigned POT_W        = 8,
  parameter int unsigned ACC_W        = 12,
  parameter int unsigned LEAK_SHIFT   = 3,
  parameter int unsigned REFRAC_STEPS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [POT_W-1:0] mult_ans,
  output logic             in_ready,
  input  logic             step,
  input  logic [ACC_W-1:0] threshold,
  output logic [ACC_W-1:0] v_mem,
  output logic             spike_out,
  output logic             refrac
`ifdef LIF_SPIKE_CNT_EN
  ,
  output logic [15:0]      spike_cnt
`endif
);

  localparam int unsigned CNT_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  typedef enum logic [1:0] {StAccum, StEval, StRefract} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   v_q, v_d;
  logic               spike_q, spike_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   v_sat;
  logic [ACC_W-1:0]   v_leak;

  assign in_ready  = (state_q != StEval);
  assign refrac    = (state_q == StRefract);
  assign v_mem     = v_q;
  assign spike_out = spike_q;

  assign accept = in_valid & in_ready;
  // One extra bit catches the carry so the sum can clamp instead of wrapping.
  assign sum    = {1'b0, v_q} + (ACC_W + 1)'(mult_ans);
  assign v_sat  = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign v_leak = v_q - (v_q >> LEAK_SHIFT);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAccum: begin
        if (accept) v_d = v_sat;
        if (step) state_d = StEval;
      end
      StEval: begin
        if (v_leak >= threshold) begin
          spike_d = 1'b1;
          v_d     = '0;
          if (REFRAC_STEPS == 0) begin
            state_d = StAccum;
          end else begin
            state_d = StRefract;
            cnt_d   = CNT_W'(REFRAC_STEPS);
          end
        end else begin
          v_d     = v_leak;
          state_d = StAccum;
        end
      end
      StRefract: begin
        v_d = '0;
        if (step) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = StAccum;
          end
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      v_q     <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LIF_SPIKE_CNT_EN
  // Counts on the same edge that raises spike_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt <= '0;
    end else if (spike_d) begin
      spike_cnt <= spike_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Directed table-driven bench for lif_membrane_integrator (ACC_W=12, LEAK_SHIFT=3, REFRAC_STEPS=2).
module tb_lif_membrane_integrator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  mult_ans;
  logic        in_ready;
  logic        step;
  logic [11:0] threshold;
  logic [11:0] v_mem;
  logic        spike_out;
  logic        refrac;
`ifdef LIF_SPIKE_CNT_EN
  logic [15:0] spike_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lif_membrane_integrator #(
    .POT_W(8), .ACC_W(12), .LEAK_SHIFT(3), .REFRAC_STEPS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .mult_ans (mult_ans),
    .in_ready (in_ready),
    .step     (step),
    .threshold(threshold),
    .v_mem    (v_mem),
    .spike_out(spike_out),
    .refrac   (refrac)
`ifdef LIF_SPIKE_CNT_EN
    ,
    .spike_cnt(spike_cnt)
`endif
  );

  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        stp;
    logic [11:0] thr;
    logic [11:0] ev;
    logic        es;
    logic        er;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vld, input logic [7:0] d, input logic stp,
                     input logic [11:0] thr, input logic [11:0] ev, input logic es,
                     input logic er, input logic erdy);
    vec_t v;
    v.vld = vld; v.d = d; v.stp = stp; v.thr = thr;
    v.ev = ev; v.es = es; v.er = er; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] ev, input logic es,
                           input logic er, input logic erdy);
    check({tag, ".v_mem"}, 32'(v_mem), 32'(ev));
    check({tag, ".spike_out"}, 32'(spike_out), 32'(es));
    check({tag, ".refrac"}, 32'(refrac), 32'(er));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
  endtask

  task automatic drive(input logic vld, input logic [7:0] d, input logic stp,
                       input logic [11:0] thr);
    @(negedge clk);
    in_valid = vld; mult_ans = d; step = stp; threshold = thr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned exp_v;

    rst_n = 1'b0; in_valid = 1'b0; mult_ans = '0; step = 1'b0; threshold = 12'd100;
    #1;
    check_all("reset", 12'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // vld  d    stp  thr   v     spk  rf  rdy
    add(1, 40,  0, 100,  40,  0, 0, 1);  // 3x accept 40
    add(1, 40,  0, 100,  80,  0, 0, 1);
    add(1, 40,  0, 100, 120,  0, 0, 1);
    add(0, 0,   1, 100, 120,  0, 0, 0);  // EVAL
    add(0, 0,   0, 100,   0,  1, 1, 1);  // 120-15=105 fires
    add(0, 0,   0, 100,   0,  0, 1, 1);  // single-cycle pulse
    add(1, 200, 0, 100,   0,  0, 1, 1);  // discarded in REFRACT
    add(0, 0,   1, 100,   0,  0, 1, 1);
    add(1, 200, 0, 100,   0,  0, 1, 1);
    add(0, 0,   1, 100,   0,  0, 0, 1);  // second step ends REFRACT
    add(1, 50,  0, 100,  50,  0, 0, 1);
    add(1, 30,  0, 100,  80,  0, 0, 1);
    add(0, 0,   1, 100,  80,  0, 0, 0);
    add(0, 0,   0, 100,  70,  0, 0, 1);  // 80-10=70 no spike
    add(1, 20,  0, 100,  90,  0, 0, 1);
    add(1, 20,  1, 100, 110,  0, 0, 0);  // accept with step
    add(0, 0,   0, 100,  97,  0, 0, 1);  // 110-13=97
    add(1, 3,   1, 100, 100,  0, 0, 0);
    add(1, 50,  1, 100,  88,  0, 0, 1);  // input and step dropped in EVAL
    add(0, 0,   0, 100,  88,  0, 0, 1);
    add(0, 0,   1, 0,    88,  0, 0, 0);
    add(0, 0,   0, 0,     0,  1, 1, 1);  // threshold 0 fires
    add(0, 0,   1, 0,     0,  0, 1, 1);
    add(0, 0,   1, 0,     0,  0, 0, 1);
    add(0, 0,   1, 0,     0,  0, 0, 0);
    add(0, 0,   0, 0,     0,  1, 1, 1);  // fires even with v_mem=0
    add(0, 0,   1, 100,   0,  0, 1, 1);
    add(0, 0,   1, 100,   0,  0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].d, vecs[i].stp, vecs[i].thr);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].er, vecs[i].erdy);
    end

    // Saturation: 17x255 clamps at 4095.
    exp_v = 0;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 8'd255, 1'b0, 12'd100);
      exp_v = (exp_v + 255 > 4095) ? 4095 : exp_v + 255;
      check($sformatf("sat%0d.v_mem", k), 32'(v_mem), exp_v);
    end
    drive(1'b1, 8'd1, 1'b0, 12'd100);
    check("sat_hold.v_mem", 32'(v_mem), 32'd4095);
    drive(1'b0, 8'd0, 1'b1, 12'd100);
    drive(1'b0, 8'd0, 1'b0, 12'd100);
    check_all("sat_fire", 12'd0, 1'b1, 1'b1, 1'b1);
`ifdef LIF_SPIKE_CNT_EN
    check("spike_cnt", 32'(spike_cnt), 32'd4);
`endif

    // Asynchronous reset while spiking in REFRACT.
    @(negedge clk);
    in_valid = 1'b0; step = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 12'd0, 1'b0, 1'b0, 1'b1);
`ifdef LIF_SPIKE_CNT_EN
    check("spike_cnt_rst", 32'(spike_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 12'd100);
    check_all("post_rst", 12'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd5, 1'b0, 12'd100);
    check_all("post_rst_acc", 12'd5, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
